// File: rtl/fft_pkg.sv
// Shared FFT front-end parameters, sample/vector types and packer state encoding.
package fft_pkg;

  localparam int unsigned DIN_W         = 9;
  localparam int unsigned LANES         = 16;
  localparam int unsigned FRAME_LEN     = 512;
  localparam int unsigned VEC_PER_FRAME = FRAME_LEN / LANES;
  localparam int unsigned LANE_CNT_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned VEC_CNT_W     = (VEC_PER_FRAME > 1) ? $clog2(VEC_PER_FRAME) : 1;
  localparam int unsigned ERR_CNT_W     = 16;

  typedef logic signed [DIN_W-1:0] sample_t;

  // Lane 0 is the leftmost (earliest) element.
  typedef logic [0:LANES-1][DIN_W-1:0] vec_t;

  typedef struct packed {
    logic sof;
    logic eof;
    vec_t re;
    vec_t im;
  } vec_beat_s;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pk_state_e;

endpackage

// File: rtl/fft_input_packer_if.sv
// Sample-in / vector-out bus of the FFT input packer.
// err_cnt exists only when INPUT_PACKER_ERRCNT_EN is defined.
interface fft_input_packer_if;
  import fft_pkg::*;

  logic    din_valid;
  logic    din_sof;
  sample_t din_re;
  sample_t din_im;
  vec_t    dout_re;
  vec_t    dout_im;
  logic    dout_valid;
  logic    dout_sof;
  logic    dout_eof;
  logic    frame_err;
`ifdef INPUT_PACKER_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output din_valid, din_sof, din_re, din_im,
    input  dout_re, dout_im, dout_valid, dout_sof, dout_eof, frame_err, err_cnt
  );
  modport slave (
    input  din_valid, din_sof, din_re, din_im,
    output dout_re, dout_im, dout_valid, dout_sof, dout_eof, frame_err, err_cnt
  );
`else
  modport master (
    output din_valid, din_sof, din_re, din_im,
    input  dout_re, dout_im, dout_valid, dout_sof, dout_eof, frame_err
  );
  modport slave (
    input  din_valid, din_sof, din_re, din_im,
    output dout_re, dout_im, dout_valid, dout_sof, dout_eof, frame_err
  );
`endif

endinterface

// File: rtl/fft_input_packer.sv
// Packs serial complex samples into LANES-wide vectors framed into FRAME_LEN blocks.
// Optional saturating violation counter enabled by INPUT_PACKER_ERRCNT_EN.
module fft_input_packer
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fft_input_packer_if.slave  io
);

  pk_state_e             state_q, state_d;
  logic [LANE_CNT_W-1:0] lane_q, lane_d;
  logic [VEC_CNT_W-1:0]  vec_q, vec_d;
  vec_t                  shadow_re_q, shadow_re_d;
  vec_t                  shadow_im_q, shadow_im_d;
  vec_beat_s             out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      vec_q       <= '0;
      shadow_re_q <= '0;
      shadow_im_q <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      vec_q       <= vec_d;
      shadow_re_q <= shadow_re_d;
      shadow_im_q <= shadow_im_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    vec_d       = vec_q;
    shadow_re_d = shadow_re_q;
    shadow_im_d = shadow_im_q;
    out_d       = out_q;
    out_d.sof   = 1'b0;
    out_d.eof   = 1'b0;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.din_valid && io.din_sof) begin
          shadow_re_d[0] = io.din_re;
          shadow_im_d[0] = io.din_im;
          lane_d         = LANE_CNT_W'(1);
          vec_d          = '0;
          state_d        = RUN;
        end
      end
      RUN: begin
        if (io.din_valid) begin
          // sof anywhere but a frame boundary aborts the frame and restarts on this sample
          if (io.din_sof && (lane_q != '0 || vec_q != '0)) begin
            err_d          = 1'b1;
            shadow_re_d[0] = io.din_re;
            shadow_im_d[0] = io.din_im;
            lane_d         = LANE_CNT_W'(1);
            vec_d          = '0;
          end else begin
            shadow_re_d[lane_q] = io.din_re;
            shadow_im_d[lane_q] = io.din_im;
            lane_d              = lane_q + LANE_CNT_W'(1);
            if (lane_q == LANE_CNT_W'(LANES - 1)) begin
              lane_d    = '0;
              valid_d   = 1'b1;
              out_d.re  = shadow_re_d;
              out_d.im  = shadow_im_d;
              out_d.sof = (vec_q == '0);
              out_d.eof = (vec_q == VEC_CNT_W'(VEC_PER_FRAME - 1));
              if (out_d.eof) begin
                vec_d   = '0;
                state_d = IDLE;
              end else begin
                vec_d = vec_q + VEC_CNT_W'(1);
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.dout_re    = out_q.re;
  assign io.dout_im    = out_q.im;
  assign io.dout_sof   = out_q.sof;
  assign io.dout_eof   = out_q.eof;
  assign io.dout_valid = valid_q;
  assign io.frame_err  = err_q;

`ifdef INPUT_PACKER_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign io.err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/fft_input_packer.md
# fft_input_packer

Serial-to-parallel front end for the module0 FFT pipeline. It accepts one complex 9-bit sample per valid cycle and packs 16 consecutive samples into one 16-lane vector. It issues that vector with a one-cycle valid pulse that drives the FFT top's `valid`, `din_re` and `din_im` inputs directly. It also frames the stream into 512-point blocks (32 vectors each) and flags framing violations.

## Interface
Parameters:
- DIN_W, 9: sample width, signed two's complement, for both re and im.
- LANES, 16: samples per output vector.
- FRAME_LEN, 512: samples per FFT frame. Must be a multiple of LANES.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  qualifies the input sample.
- din_sof  in  1  start-of-frame; meaningful only with din_valid.
- din_re  in  DIN_W  signed real sample.
- din_im  in  DIN_W  signed imaginary sample.
- dout_re  out  [DIN_W-1:0] x [0:LANES-1]  packed real vector; lane 0 holds the earliest sample.
- dout_im  out  [DIN_W-1:0] x [0:LANES-1]  packed imaginary vector.
- dout_valid  out  1  one-cycle pulse per complete vector.
- dout_sof  out  1  high with dout_valid on vector 0 of a frame.
- dout_eof  out  1  high with dout_valid on vector 31 of a frame.
- frame_err  out  1  one-cycle pulse on a framing violation.
- err_cnt  out  16  saturating violation count. Present only with INPUT_PACKER_ERRCNT_EN.

## Operation
- FSM states:
  - IDLE: waiting for a frame start.
  - RUN: collecting samples.
- IDLE:
  - din_valid without din_sof: sample dropped silently.
  - din_valid with din_sof: sample written to lane 0; lane_cnt=1, vec_cnt=0; go to RUN.
- RUN, din_valid without din_sof:
  - Sample is written to the lane at lane_cnt (0..LANES-1); lane_cnt increments.
  - On lane_cnt==LANES-1: the completed vector (including the current sample) is copied to the dout registers; lane_cnt wraps to 0; vec_cnt increments.
- RUN, din_valid with din_sof while lane_cnt!=0 or vec_cnt!=0 (mid-frame restart):
  - frame_err pulses.
  - The partial vector and the remainder of the frame are discarded; no dout_valid is emitted for them.
  - The current sample becomes lane 0 of a new frame: lane_cnt=1, vec_cnt=0.
- RUN with lane_cnt==0 and vec_cnt==0 (between frames): din_sof is legal and starts the frame normally.
- Last vector of a frame (vec_cnt==FRAME_LEN/LANES-1, i.e. 31): dout_eof is asserted; counters clear; FSM returns to IDLE. The next frame requires din_sof.
- din_valid low: no state change. Gaps of any length are allowed inside a frame.
- Outputs: dout_re/dout_im hold the last emitted vector between pulses. The values are pass-through with no arithmetic and no width change.
- Lane write path: a shadow vector register is written per lane. Only the vector copy drives dout, so dout never shows a partial vector.

## Timing
- Latency: the 16th sample accepted at edge t produces dout_valid, dout_sof/dout_eof and the new vector all registered at edge t+1.
- Back-to-back: with din_valid held high, dout_valid pulses every 16 cycles. A frame takes 512 cycles plus 1 cycle of latency.
- Throughput: no backpressure exists and the downstream FFT always accepts. The source must not exceed 1 sample per cycle.
- frame_err is registered, asserted the cycle after the offending sample.
- Reset values (rst high, async):
  - FSM = IDLE; lane_cnt = 0; vec_cnt = 0.
  - dout_re = 0; dout_im = 0.
  - dout_valid, dout_sof, dout_eof, frame_err = 0.
  - err_cnt = 0.
- Reset mid-frame: the partial frame is lost. The first post-reset sample is accepted only with din_sof.
- Single-vector frame (FRAME_LEN==LANES): dout_sof and dout_eof are asserted together.

## Configuration
- INPUT_PACKER_ERRCNT_EN defined:
  - err_cnt port exists.
  - Increments on each frame_err pulse; saturates at 16'hFFFF.
  - Cleared only by rst.
- Undefined: err_cnt port and counter are absent. frame_err behaviour is unchanged.

## Structure
- Shared package fft_pkg holds:
  - DIN_W, LANES, FRAME_LEN;
  - derived VEC_PER_FRAME = FRAME_LEN/LANES;
  - LANE_CNT_W = $clog2(LANES), VEC_CNT_W = $clog2(VEC_PER_FRAME);
  - packer state enum {IDLE, RUN}.
- Single module; no sub-module is warranted.

## Test plan
- Reset, then a frame of 512 contiguous samples with re=n[8:0], im=-n, sof on n=0:
  - 32 dout_valid pulses, 16 cycles apart;
  - vector 0 lanes hold re 0..15;
  - dout_sof on pulse 1, dout_eof on pulse 32.
- Same frame with din_valid toggling 1/0:
  - identical vectors;
  - pulses 32 cycles apart;
  - no frame_err.
- 20 valid samples without sof after reset, then a sof frame:
  - first 20 samples dropped;
  - first vector lane 0 equals the sof sample.
- sof injected at sample 100 of a frame:
  - frame_err pulses once;
  - 6 vectors from the aborted frame emitted;
  - next dout_sof vector starts with the injected sample;
  - err_cnt=1 when INPUT_PACKER_ERRCNT_EN is defined.
- rst asserted at sample 300 and released:
  - all outputs 0 immediately;
  - no dout_valid until a new sof plus 16 samples.
- Boundary values re=-256, im=255 in all lanes: output lanes equal exactly -256/255 with no sign corruption.
